uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 27 ++
 rtl/baud_tick.sv | 44 ++++
 rtl/uart_rx.sv | 140 ++++++++++++++
 tb/tb_uart_rx.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART constants (12 MHz divisors) and FSM state encoding.
// Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package uart_pkg;

    localparam int unsigned BAUD_DIV_115200 = 104;
    localparam int unsigned BAUD_DIV_57600  = 208;
    localparam int unsigned BAUD_DIV_9600   = 1250;

    localparam int unsigned TIMER_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_DATA    = 3'd2,
        ST_STOP    = 3'd3,
        ST_WAIT_HI = 3'd4
    } uart_state_e;

endpackage

`default_nettype wire

// File: rtl/baud_tick.sv
// ============================================================================
// Module      : baud_tick
// Description : Loadable 16-bit down-counter; tick is high while it holds 1.
// Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module baud_tick
    import uart_pkg::*;
(
    input  logic               clk,
    input  logic               rstn,
    input  logic               load,
    input  logic [TIMER_W-1:0] reload,
    output logic               tick
);

    logic [TIMER_W-1:0] cnt_q;
    logic [TIMER_W-1:0] cnt_d;

    assign tick = (cnt_q == TIMER_W'(1));

    // Parks at zero after expiry instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = reload;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - TIMER_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
// Module      : uart_rx
// Description : 8N1 UART receiver with mid-bit sampling and framing-error pulse.
// Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_DIV = BAUD_DIV_115200
)
(
    input  logic       clk,
    input  logic       rstn,
    input  logic       rx,
    output logic [7:0] data,
    output logic       rcv,
    output logic       ferr,
    output logic       busy
);

    localparam logic [TIMER_W-1:0] c_bit_cycles  = TIMER_W'(BAUD_DIV);
    localparam logic [TIMER_W-1:0] c_half_cycles = TIMER_W'(BAUD_DIV / 2);

    uart_state_e        state_q, state_d;
    logic [1:0]         sync_q, sync_d;
    logic [2:0]         idx_q, idx_d;
    logic [7:0]         shift_q, shift_d;
    logic [7:0]         data_q, data_d;
    logic               rcv_q, rcv_d;
    logic               ferr_q, ferr_d;
    logic               rxs;
    logic               tmr_load;
    logic [TIMER_W-1:0] tmr_reload;
    logic               tmr_tick;

    assign sync_d = {sync_q[0], rx};
    assign rxs    = sync_q[1];

    baud_tick u_baud_tick (
        .clk    (clk),
        .rstn   (rstn),
        .load   (tmr_load),
        .reload (tmr_reload),
        .tick   (tmr_tick)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        data_d     = data_q;
        rcv_d      = 1'b0;
        ferr_d     = 1'b0;
        tmr_load   = 1'b0;
        tmr_reload = c_bit_cycles;

        case (state_q)
            ST_IDLE: begin
                if (!rxs) begin
                    state_d    = ST_START;
                    tmr_load   = 1'b1;
                    tmr_reload = c_half_cycles;
                end
            end
            ST_START: begin
                if (tmr_tick) begin
                    // A start bit that is high again at mid-bit was only a glitch.
                    if (!rxs) begin
                        state_d  = ST_DATA;
                        idx_d    = 3'd0;
                        tmr_load = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (tmr_tick) begin
                    shift_d[idx_q] = rxs;
                    tmr_load       = 1'b1;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (tmr_tick) begin
                    if (rxs) begin
                        data_d  = shift_q;
                        rcv_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_WAIT_HI;
                    end
                end
            end
            ST_WAIT_HI: begin
                if (rxs) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            sync_q  <= 2'b11;
            idx_q   <= 3'd0;
            shift_q <= 8'h00;
            data_q  <= 8'h00;
            rcv_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            rcv_q   <= rcv_d;
            ferr_q  <= ferr_d;
        end
    end

    assign data = data_q;
    assign rcv  = rcv_q;
    assign ferr = ferr_q;
    assign busy = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
// Module      : tb_uart_rx
// Description : Self-checking bench for uart_rx at BAUD_DIV=8 and BAUD_DIV=104.
// Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_rx;

    localparam int B  = 8;
    localparam int H  = B / 2;
    localparam int B2 = 104;

    logic       clk  = 1'b0;
    logic       rstn = 1'b0;
    logic       rx   = 1'b1;
    logic       rx2  = 1'b1;
    logic [7:0] data, data2;
    logic       rcv, ferr, busy;
    logic       rcv2, ferr2, busy2;

    int n_tests = 0;
    int n_fail  = 0;

    // Event log: bit 8 set = rcv with byte, clear = ferr.
    logic [8:0] ev_q[$];
    int         viol        = 0;
    int         busy_cycles = 0;
    int         busy_rises  = 0;
    logic       busy_prev   = 1'b0;
    logic [7:0] prev_data   = 8'h00;
    int         ev2_rcv     = 0;
    int         ev2_ferr    = 0;
    logic [7:0] last2       = 8'h00;
    logic [7:0] exp_data    = 8'h00;

    always #5 clk = ~clk;

    uart_rx #(.BAUD_DIV(B)) dut (
        .clk  (clk),
        .rstn (rstn),
        .rx   (rx),
        .data (data),
        .rcv  (rcv),
        .ferr (ferr),
        .busy (busy)
    );

    uart_rx #(.BAUD_DIV(B2)) dut104 (
        .clk  (clk),
        .rstn (rstn),
        .rx   (rx2),
        .data (data2),
        .rcv  (rcv2),
        .ferr (ferr2),
        .busy (busy2)
    );

    always @(negedge clk) begin
        if (!rstn) begin
            prev_data <= data;
            busy_prev <= 1'b0;
        end else begin
            if (rcv && ferr) viol <= viol + 1;
            if (!rcv && (data !== prev_data)) viol <= viol + 1;
            if (rcv)  ev_q.push_back({1'b1, data});
            if (ferr) ev_q.push_back({1'b0, 8'h00});
            if (busy) busy_cycles <= busy_cycles + 1;
            if (busy && !busy_prev) busy_rises <= busy_rises + 1;
            prev_data <= data;
            busy_prev <= busy;
            if (rcv2) begin
                ev2_rcv <= ev2_rcv + 1;
                last2   <= data2;
            end
            if (ferr2) ev2_ferr <= ev2_ferr + 1;
        end
    end

    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int bl, input bit on2);
        logic [9:0] bits;
        bits = {stop_ok, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            if (on2) rx2 = bits[i];
            else     rx  = bits[i];
            repeat (bl) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        #1;
        n_tests++;
        if ({data, rcv, ferr, busy} !== 11'h000) begin
            n_fail++;
            $display("FAIL reset_t0: data/rcv/ferr/busy got %h expected 000", {data, rcv, ferr, busy});
        end
        repeat (3) @(negedge clk);
        n_tests++;
        if ({data2, rcv2, ferr2, busy2, data, rcv, ferr, busy} !== 22'h0) begin
            n_fail++;
            $display("FAIL reset_hold: outputs got %h expected 0", {data2, rcv2, ferr2, busy2, data, rcv, ferr, busy});
        end
        rstn = 1'b1;
        repeat (4) @(negedge clk);
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: busy got %b expected 0", busy);
        end
    endtask

    task automatic test_single();
        int b0, r0;
        ev_q.delete();
        b0 = busy_cycles;
        r0 = busy_rises;
        send_frame(8'h55, 1'b1, B, 1'b0);
        repeat (2 * B) @(negedge clk);
        exp_data = 8'h55;
        n_tests++;
        if (ev_q.size() != 1 || ev_q[0] !== {1'b1, 8'h55}) begin
            n_fail++;
            $display("FAIL single_55: events got %0d first %h expected 1 x %h", ev_q.size(),
                     (ev_q.size() > 0) ? ev_q[0] : 9'h0, {1'b1, 8'h55});
        end
        n_tests++;
        if (data !== 8'h55) begin
            n_fail++;
            $display("FAIL single_data: got %h expected 55", data);
        end
        n_tests++;
        if (busy_cycles - b0 != H + 9 * B || busy_rises - r0 != 1) begin
            n_fail++;
            $display("FAIL single_busy: cycles %0d rises %0d expected %0d and 1",
                     busy_cycles - b0, busy_rises - r0, H + 9 * B);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq [3];
        seq[0] = 8'h00; seq[1] = 8'hFF; seq[2] = 8'hA5;
        ev_q.delete();
        for (int i = 0; i < 3; i++) send_frame(seq[i], 1'b1, B, 1'b0);
        repeat (2 * B) @(negedge clk);
        n_tests++;
        if (ev_q.size() != 3) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d events expected 3", ev_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_tests++;
                if (ev_q[i] !== {1'b1, seq[i]}) begin
                    n_fail++;
                    $display("FAIL b2b_byte%0d: got %h expected %h", i, ev_q[i], {1'b1, seq[i]});
                end
            end
        end
        exp_data = 8'hA5;
    endtask

    task automatic test_framing();
        ev_q.delete();
        send_frame(8'h3C, 1'b0, B, 1'b0);
        rx = 1'b1;
        repeat (2 * B) @(negedge clk);
        n_tests++;
        if (ev_q.size() != 1 || ev_q[0] !== 9'h000) begin
            n_fail++;
            $display("FAIL ferr_3c: events got %0d first %h expected 1 x 000", ev_q.size(),
                     (ev_q.size() > 0) ? ev_q[0] : 9'h1FF);
        end
        n_tests++;
        if (data !== exp_data) begin
            n_fail++;
            $display("FAIL ferr_data: got %h expected %h", data, exp_data);
        end
    endtask

    task automatic test_glitch();
        int r0;
        ev_q.delete();
        r0 = busy_rises;
        rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        repeat (H + 1) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || busy_rises - r0 != 1) begin
            n_fail++;
            $display("FAIL glitch_busy: busy %b rises %0d expected 0 and 1", busy, busy_rises - r0);
        end
        repeat (2 * B) @(negedge clk);
        n_tests++;
        if (ev_q.size() != 0) begin
            n_fail++;
            $display("FAIL glitch_events: got %0d expected 0", ev_q.size());
        end
    endtask

    task automatic test_break();
        ev_q.delete();
        rx = 1'b0;
        repeat (30 * B) @(negedge clk);
        rx = 1'b1;
        repeat (2 * B) @(negedge clk);
        n_tests++;
        if (ev_q.size() != 1 || ev_q[0] !== 9'h000) begin
            n_fail++;
            $display("FAIL break_ferr: events got %0d expected exactly one ferr", ev_q.size());
        end
        send_frame(8'h81, 1'b1, B, 1'b0);
        repeat (2 * B) @(negedge clk);
        exp_data = 8'h81;
        n_tests++;
        if (ev_q.size() != 2 || ev_q[ev_q.size() - 1] !== {1'b1, 8'h81}) begin
            n_fail++;
            $display("FAIL break_81: events got %0d last %h expected 2 with %h", ev_q.size(),
                     ev_q[ev_q.size() - 1], {1'b1, 8'h81});
        end
    endtask

    task automatic test_reset_midframe();
        logic [9:0] bits;
        bits = {1'b1, 8'hE7, 1'b0};
        ev_q.delete();
        for (int i = 0; i < 5; i++) begin
            rx = bits[i];
            repeat (B) @(negedge clk);
        end
        rx = bits[5];
        repeat (H) @(negedge clk);
        rstn = 1'b0;
        #1;
        n_tests++;
        if ({data, rcv, ferr, busy} !== 11'h000) begin
            n_fail++;
            $display("FAIL midrst_async: data/rcv/ferr/busy got %h expected 000", {data, rcv, ferr, busy});
        end
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (2 * B) @(negedge clk);
        exp_data = 8'h00;
        n_tests++;
        if (ev_q.size() != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_quiet: events %0d busy %b expected 0 and 0", ev_q.size(), busy);
        end
        send_frame(8'h12, 1'b1, B, 1'b0);
        repeat (2 * B) @(negedge clk);
        exp_data = 8'h12;
        n_tests++;
        if (ev_q.size() != 1 || ev_q[0] !== {1'b1, 8'h12}) begin
            n_fail++;
            $display("FAIL midrst_12: events got %0d expected 1 x %h", ev_q.size(), {1'b1, 8'h12});
        end
    endtask

    task automatic test_random();
        logic [8:0] exp_ev[$];
        logic [7:0] b;
        bit         ok;
        int         gap;
        ev_q.delete();
        for (int n = 0; n < 24; n++) begin
            b  = 8'($urandom_range(0, 255));
            ok = ($urandom_range(0, 3) != 0);
            send_frame(b, ok, B, 1'b0);
            if (ok) begin
                exp_ev.push_back({1'b1, b});
                exp_data = b;
            end else begin
                exp_ev.push_back(9'h000);
            end
            rx  = 1'b1;
            gap = $urandom_range(0, 2 * B) + (ok ? 0 : B);
            repeat (gap) @(negedge clk);
        end
        repeat (2 * B) @(negedge clk);
        n_tests++;
        if (ev_q.size() != exp_ev.size()) begin
            n_fail++;
            $display("FAIL rand_count: got %0d events expected %0d", ev_q.size(), exp_ev.size());
        end else begin
            for (int i = 0; i < exp_ev.size(); i++) begin
                n_tests++;
                if (ev_q[i] !== exp_ev[i]) begin
                    n_fail++;
                    $display("FAIL rand_ev%0d: got %h expected %h", i, ev_q[i], exp_ev[i]);
                end
            end
        end
        n_tests++;
        if (data !== exp_data) begin
            n_fail++;
            $display("FAIL rand_data: got %h expected %h", data, exp_data);
        end
    endtask

    task automatic test_baud104();
        int         r0, f0;
        logic [7:0] b;
        r0 = ev2_rcv;
        f0 = ev2_ferr;
        b  = 8'($urandom_range(1, 254));
        send_frame(b, 1'b1, B2, 1'b1);
        repeat (2 * B2) @(negedge clk);
        n_tests++;
        if (ev2_rcv - r0 != 1 || ev2_ferr - f0 != 0 || last2 !== b) begin
            n_fail++;
            $display("FAIL baud104: rcv %0d ferr %0d data %h expected 1 0 %h",
                     ev2_rcv - r0, ev2_ferr - f0, last2, b);
        end
    endtask

    task automatic test_invariants();
        n_tests++;
        if (viol != 0) begin
            n_fail++;
            $display("FAIL invariants: got %0d rcv/ferr overlap or data-hold violations expected 0", viol);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_framing();
        test_glitch();
        test_break();
        test_reset_midframe();
        test_random();
        test_baud104();
        test_invariants();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
